sha256_dhash_core: RTL and testbench

- Self-contained SHA-256 compression engine.
- Accepts 512-bit pre-padded message blocks over a valid/ready handshake and chains multi-block messages.
- Optional mode: automatically performs the second (double) hash over the 256-bit digest. Padding for that second pass is generated internally.
- Rounds per cycle are parametrised. The same core serves both the area-optimised miner and the throughput miner, and replaces the externally sequenced per-word hash datapath.

---
 rtl/sha256_pkg.sv | 81 ++++++++
 rtl/sha256_round.sv | 27 ++
 rtl/sha256_dhash_core.sv | 171 +++++++++++++++++
 tb/tb_sha256_dhash_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, round functions and core state type
//
// Shared by sha256_round and sha256_dhash_core:
//   IV, K_TABLE        initial hash value and round constants
//   PAD_WORD_FIRST/LEN padding words for a 256-bit second-pass message
//   ch/maj/bsig*/ssig* SHA-256 logical functions
//   add8               per-word mod 2^32 addition of two 8-word states
//   blk_word           extract word j (W0 = MSBs) from a 512-bit block
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // The second pass always hashes exactly 256 bits, so its padding is fixed.
  localparam logic [31:0] PAD_WORD_FIRST = 32'h80000000;
  localparam logic [31:0] PAD_WORD_LEN   = 32'h00000100;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

  function automatic logic [31:0] blk_word(input logic [511:0] blk, input int j);
    return blk[511 - 32*j -: 32];
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
//
// Ports:
//   state_in  in  256  a..h, a in bits 255:224
//   k         in  32   round constant K[t]
//   w         in  32   schedule word W[t]
//   state_out out 256  a'..h' after the round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;

  assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
  assign t2 = bsig0(a) + maj(a, b, c);

  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_dhash_core.sv
// rtl/sha256_dhash_core.sv - SHA-256 compression engine with optional double hash
//
// Parameter UNROLL: rounds per clock, one of 1, 2, 4, 8.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   blk_valid/blk_ready block handshake; blk_data is a padded 512-bit block
//   blk_first           start a new message from IV
//   blk_last            final block of the message
//   mode_double         with blk_last: return SHA256(SHA256(msg))
//   digest_valid/ready  digest handshake; digest = H0..H7, H0 in 255:224
//   busy                high in any state except IDLE
module sha256_dhash_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         mode_double,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
);

  localparam logic [5:0] T_STEP = 6'(UNROLL);
  localparam logic [5:0] T_LAST = 6'(64 - UNROLL);

  state_t       state;
  logic [5:0]   t;
  logic         pass;
  logic         last_f;
  logic         dbl_f;
  logic [255:0] h_chain;   // base of the current block; becomes H after ADD
  logic [255:0] work;      // a..h
  logic [255:0] round_out;
  logic [255:0] h_sum;
  logic [511:0] pass2_blk;
  logic [255:0] accept_base;

  // w_win[0] always holds W[t]; the window slides by UNROLL words per cycle.
  logic [31:0]  w_win [16];
  logic [31:0]  w_ext [16 + UNROLL];

  // Extension words depend on earlier extension words when UNROLL > 2,
  // so they are generated in order inside one block.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      w_ext[j] = w_win[j];
    end
    for (int j = 16; j < 16 + UNROLL; j++) begin
      w_ext[j] = ssig1(w_ext[j-2]) + w_ext[j-7] + ssig0(w_ext[j-15]) + w_ext[j-16];
    end
  end

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    logic [255:0] st_in;
    logic [255:0] st_out;
    logic [5:0]   kidx;

    if (g == 0) begin : g_head
      assign st_in = work;
    end else begin : g_tail
      assign st_in = g_rnd[g-1].st_out;
    end

    assign kidx = t + 6'(g);

    sha256_round u_round (
      .state_in  (st_in),
      .k         (K_TABLE[kidx]),
      .w         (w_win[g]),
      .state_out (st_out)
    );
  end

  assign round_out   = g_rnd[UNROLL-1].st_out;
  assign h_sum       = add8(h_chain, work);
  assign pass2_blk   = {h_sum, PAD_WORD_FIRST, 192'h0, PAD_WORD_LEN};
  assign accept_base = blk_first ? IV : h_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      blk_ready    <= 1'b1;
      digest_valid <= 1'b0;
      digest       <= '0;
      busy         <= 1'b0;
      h_chain      <= IV;
      work         <= '0;
      t            <= '0;
      pass         <= 1'b0;
      last_f       <= 1'b0;
      dbl_f        <= 1'b0;
      for (int j = 0; j < 16; j++) begin
        w_win[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            for (int j = 0; j < 16; j++) begin
              w_win[j] <= blk_word(blk_data, j);
            end
            h_chain   <= accept_base;
            work      <= accept_base;
            last_f    <= blk_last;
            dbl_f     <= blk_last & mode_double;
            t         <= '0;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ROUND;
          end
        end

        ROUND: begin
          work <= round_out;
          for (int j = 0; j < 16; j++) begin
            w_win[j] <= w_ext[j + UNROLL];
          end
          t <= t + T_STEP;
          if (t == T_LAST) begin
            state <= ADD;
          end
        end

        ADD: begin
          if (!last_f) begin
            h_chain   <= h_sum;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (dbl_f && !pass) begin
            // First digest becomes the message of the second pass.
            for (int j = 0; j < 16; j++) begin
              w_win[j] <= blk_word(pass2_blk, j);
            end
            h_chain <= IV;
            work    <= IV;
            pass    <= 1'b1;
            t       <= '0;
            state   <= ROUND;
          end else begin
            h_chain      <= h_sum;
            digest       <= h_sum;
            digest_valid <= 1'b1;
            state        <= DONE;
          end
        end

        DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            pass         <= 1'b0;
            blk_ready    <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_dhash_core.sv
// tb/tb_sha256_dhash_core.sv - directed vector bench for sha256_dhash_core
module tb_sha256_dhash_core;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_DBL   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

  // Instance i runs with UNROLL = 1 << i: index 0 -> 1, 1 -> 2, 2 -> 4.
  logic         clk = 1'b0;
  logic         rst;
  logic         bv [3];
  logic         br [3];
  logic [511:0] bd [3];
  logic         bf [3];
  logic         bl [3];
  logic         md [3];
  logic         dv [3];
  logic         dr [3];
  logic [255:0] dg [3];
  logic         bz [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    sha256_dhash_core #(.UNROLL(1 << i)) dut (
      .clk          (clk),
      .rst          (rst),
      .blk_valid    (bv[i]),
      .blk_ready    (br[i]),
      .blk_data     (bd[i]),
      .blk_first    (bf[i]),
      .blk_last     (bl[i]),
      .mode_double  (md[i]),
      .digest_valid (dv[i]),
      .digest_ready (dr[i]),
      .digest       (dg[i]),
      .busy         (bz[i])
    );
  end

  typedef struct {
    int           dut;
    logic [511:0] blk;
    logic         dbl;
    logic [255:0] exp;
    int           lat;
    string        name;
  } vec_t;

  vec_t vec [7];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_block(input int i, input logic [511:0] d, input logic f, input logic l,
                            input logic m);
    @(negedge clk);
    check("ready_before_send", br[i], 1'b1);
    bv[i] = 1'b1; bd[i] = d; bf[i] = f; bl[i] = l; md[i] = m;
    @(posedge clk); #1;
    bv[i] = 1'b0; bf[i] = 1'b0; bl[i] = 1'b0; md[i] = 1'b0;
  endtask

  // Edges after the accept edge until digest_valid is seen; -1 on timeout.
  task automatic wait_valid(input int i, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (dv[i]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int i, output int lat, output logic saw_dv);
    lat = -1;
    saw_dv = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      saw_dv = saw_dv | dv[i];
      if (br[i]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic take_digest(input int i, input logic [255:0] exp);
    @(negedge clk);
    dr[i] = 1'b1;
    @(posedge clk); #1;
    dr[i] = 1'b0;
    check("valid_cleared", dv[i], 1'b0);
    check("ready_after_take", br[i], 1'b1);
    check("busy_after_take", bz[i], 1'b0);
    check("digest_retained", dg[i], exp);
  endtask

  initial begin
    int   lat;
    logic saw;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bv[i] = 1'b0; bd[i] = '0; bf[i] = 1'b0; bl[i] = 1'b0; md[i] = 1'b0; dr[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", br[i], 1'b1);
      check("reset_valid", dv[i], 1'b0);
      check("reset_digest", dg[i], 256'h0);
      check("reset_busy", bz[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    vec[0] = '{0, BLK_ABC,   1'b0, D_ABC,   65, "abc_u1"};
    vec[1] = '{2, BLK_EMPTY, 1'b0, D_EMPTY, 17, "empty_u4"};
    vec[2] = '{1, BLK_ABC,   1'b1, D_DBL,   66, "abc_double_u2"};
    vec[3] = '{2, BLK_ABC,   1'b0, D_ABC,   17, "abc_u4"};
    vec[4] = '{0, BLK_EMPTY, 1'b0, D_EMPTY, 65, "empty_u1"};
    vec[5] = '{2, BLK_ABC,   1'b1, D_DBL,   34, "abc_double_u4"};
    vec[6] = '{1, BLK_EMPTY, 1'b0, D_EMPTY, 33, "empty_u2"};

    for (int v = 0; v < 7; v++) begin
      send_block(vec[v].dut, vec[v].blk, 1'b1, 1'b1, vec[v].dbl);
      check({vec[v].name, "_busy_running"}, bz[vec[v].dut], 1'b1);
      wait_valid(vec[v].dut, lat);
      check({vec[v].name, "_latency"}, lat, vec[v].lat);
      check({vec[v].name, "_digest"}, dg[vec[v].dut], vec[v].exp);
      check({vec[v].name, "_busy_done"}, bz[vec[v].dut], 1'b1);
      take_digest(vec[v].dut, vec[v].exp);
    end

    // Two-block message; mode_double on a non-last block must be ignored.
    send_block(0, BLK_TWO1, 1'b1, 1'b0, 1'b1);
    wait_ready(0, lat, saw);
    check("two_block_ready_gap", lat, 65);
    check("two_block_no_early_valid", saw, 1'b0);
    send_block(0, BLK_TWO2, 1'b0, 1'b1, 1'b0);
    wait_valid(0, lat);
    check("two_block_latency", lat, 65);
    check("two_block_digest", dg[0], D_TWO);
    take_digest(0, D_TWO);

    // blk_first mid-message discards the partial chain.
    send_block(2, BLK_TWO1, 1'b1, 1'b0, 1'b0);
    wait_ready(2, lat, saw);
    check("restart_ready_gap", lat, 17);
    send_block(2, BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_valid(2, lat);
    check("restart_digest", dg[2], D_ABC);
    take_digest(2, D_ABC);

    // digest_ready while idle does nothing.
    @(negedge clk);
    dr[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_kept", br[1], 1'b1);
    check("idle_valid_low", dv[1], 1'b0);
    dr[1] = 1'b0;

    // Backpressure: digest held stable while the consumer stalls.
    send_block(1, BLK_ABC, 1'b1, 1'b1, 1'b0);
    wait_valid(1, lat);
    check("bp_latency", lat, 33);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_valid_held", dv[1], 1'b1);
      check("bp_digest_stable", dg[1], D_ABC);
      check("bp_ready_low", br[1], 1'b0);
    end
    take_digest(1, D_ABC);

    // Asynchronous reset in the middle of ROUND (t = 30 on UNROLL=1).
    send_block(0, BLK_ABC, 1'b1, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("midreset_ready", br[i], 1'b1);
      check("midreset_valid", dv[i], 1'b0);
      check("midreset_digest", dg[i], 256'h0);
      check("midreset_busy", bz[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    // blk_first=0 here: the result is correct only if the chain went back to IV.
    send_block(0, BLK_ABC, 1'b0, 1'b1, 1'b0);
    wait_valid(0, lat);
    check("post_reset_latency", lat, 65);
    check("post_reset_digest", dg[0], D_ABC);
    take_digest(0, D_ABC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
